vga_frame_reader: RTL and testbench

- Pixel fetch stage between the VGA timing generator and the on-chip frame-buffer RAM.
- Maps the active screen area onto a stored IMG_W x IMG_H image, upscaled by 2^SCALE_LOG2 and placed at offset (X0,Y0). Generates RAM read addresses incrementally with counters, not a multiplier.
- Aligns returned RAM data with a delayed video-active flag and expands it to 8-bit R/G/B, in grayscale or RGB332 mode. Pixels outside the image window get a border colour.

---
 rtl/vga_frame_reader.sv | 158 +++++++++++++++
 tb/tb_vga_frame_reader.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// Pixel fetch stage: maps the active screen window onto an upscaled frame-buffer image and
// expands RAM bytes to RGB. Optional test pattern is enabled by VGA_READER_TEST_PATTERN_EN.
module vga_frame_reader #(
    parameter int          IMG_W      = 160,
    parameter int          IMG_H      = 120,
    parameter int          SCALE_LOG2 = 2,
    parameter int          X0         = 0,
    parameter int          Y0         = 0,
    parameter int          COORD_W    = 10,
    parameter int          ADDR_W     = 15,
    parameter int          MEM_LAT    = 1,
    parameter logic [23:0] BORDER_RGB = 24'h000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               active,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               pix_mode,
`ifdef VGA_READER_TEST_PATTERN_EN
    input  logic               test_en,
`endif
    output logic [ADDR_W-1:0]  read_addr,
    input  logic [7:0]         mem_data,
    output logic               out_active,
    output logic [7:0]         r,
    output logic [7:0]         g,
    output logic [7:0]         b
);

    localparam int S  = 1 << SCALE_LOG2;
    localparam int SW = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
    localparam logic [SW-1:0]      SUB_LAST = SW'(S - 1);
    localparam logic [COORD_W:0]   X_LO     = (COORD_W+1)'(X0);
    localparam logic [COORD_W:0]   X_HI     = (COORD_W+1)'(X0 + IMG_W * S);
    localparam logic [COORD_W:0]   Y_LO     = (COORD_W+1)'(Y0);
    localparam logic [COORD_W:0]   Y_HI     = (COORD_W+1)'(Y0 + IMG_H * S);
    localparam logic [ADDR_W-1:0]  ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0]  ROW_LAST = ADDR_W'((IMG_H - 1) * IMG_W);

    logic              in_win, in_win_q, frame_valid;
    logic              fetch, line_end, row_adv;
    logic [SW-1:0]     xsub, ysub;
    logic [ADDR_W-1:0] col, row_base;
    logic [MEM_LAT:0]  act_p, win_p, vis_p, mode_p;

    assign in_win = active
                 && ({1'b0, pix_x} >= X_LO) && ({1'b0, pix_x} < X_HI)
                 && ({1'b0, pix_y} >= Y_LO) && ({1'b0, pix_y} < Y_HI);

    // Counters only run inside a valid frame; frame_start takes priority over everything else.
    assign fetch    = frame_valid && !frame_start && in_win;
    assign line_end = frame_valid && !frame_start && !in_win && in_win_q;
    assign row_adv  = line_end && (ysub == SUB_LAST) && (row_base != ROW_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_valid <= 1'b0;
            in_win_q    <= 1'b0;
            read_addr   <= '0;
            xsub        <= '0;
            ysub        <= '0;
            col         <= '0;
            row_base    <= '0;
        end else begin
            in_win_q <= in_win;
            if (frame_start) begin
                frame_valid <= 1'b1;
                xsub        <= '0;
                ysub        <= '0;
                col         <= '0;
                row_base    <= '0;
                if (in_win)
                    read_addr <= '0;
            end else if (fetch) begin
                read_addr <= row_base + col;
                if (xsub == SUB_LAST) begin
                    xsub <= '0;
                    col  <= col + 1'b1;
                end else begin
                    xsub <= xsub + 1'b1;
                end
            end else if (line_end) begin
                col  <= '0;
                xsub <= '0;
                ysub <= (ysub == SUB_LAST) ? '0 : ysub + 1'b1;
                if (row_adv)
                    row_base <= row_base + ROW_STEP;
            end
        end
    end

    // Side-band flags travel alongside the RAM access so they meet mem_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_p  <= '0;
            win_p  <= '0;
            vis_p  <= '0;
            mode_p <= '0;
        end else begin
            act_p  <= {act_p[MEM_LAT-1:0], active};
            win_p  <= {win_p[MEM_LAT-1:0], in_win};
            vis_p  <= {vis_p[MEM_LAT-1:0], frame_valid | frame_start};
            mode_p <= {mode_p[MEM_LAT-1:0], pix_mode};
        end
    end

`ifdef VGA_READER_TEST_PATTERN_EN
    logic [7:0]  row_idx;
    logic [16:0] tp_p [MEM_LAT+1];

    always_ff @(posedge clk) begin
        if (rst || frame_start)
            row_idx <= '0;
        else if (row_adv)
            row_idx <= row_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= MEM_LAT; i++)
                tp_p[i] <= '0;
        end else begin
            tp_p[0] <= {test_en, col[7:0], row_idx};
            for (int i = 1; i <= MEM_LAT; i++)
                tp_p[i] <= tp_p[i-1];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_active <= 1'b0;
            r          <= '0;
            g          <= '0;
            b          <= '0;
        end else begin
            out_active <= act_p[MEM_LAT];
            if (!act_p[MEM_LAT] || !vis_p[MEM_LAT])
                {r, g, b} <= 24'h000000;
            else if (!win_p[MEM_LAT])
                {r, g, b} <= BORDER_RGB;
`ifdef VGA_READER_TEST_PATTERN_EN
            else if (tp_p[MEM_LAT][16])
                {r, g, b} <= {tp_p[MEM_LAT][15:8], tp_p[MEM_LAT][7:0],
                              tp_p[MEM_LAT][15:8] ^ tp_p[MEM_LAT][7:0]};
`endif
            else if (mode_p[MEM_LAT])
                {r, g, b} <= {mem_data[7:5], mem_data[7:5], mem_data[7:6],
                              mem_data[4:2], mem_data[4:2], mem_data[4:3],
                              mem_data[1:0], mem_data[1:0], mem_data[1:0], mem_data[1:0]};
            else
                {r, g, b} <= {mem_data, mem_data, mem_data};
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader: default instance plus one with X0=80 and a red border,
// each fed by a one-cycle-latency RAM model.
module tb_vga_frame_reader;

    logic        clk = 1'b0;
    logic        rst, frame_start, active, pix_mode;
    logic [9:0]  pix_x, pix_y;
    logic [14:0] addr_a, addr_b;
    logic [7:0]  mem_a, mem_b;
    logic        act_a, act_b;
    logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

    logic        mem_const_en;
    logic [7:0]  mem_const;
    logic [23:0] exp332;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit chk_b   = 1'b1;
    bit fv      = 1'b0;

    logic [14:0] e_addr   [2];
    logic        hist_act [8];
    logic [23:0] hist_rgb [2][8];
    int          x0s      [2] = '{0, 80};
    logic [23:0] borders  [2] = '{24'h000000, 24'hFF0000};

    always #5 clk = ~clk;

    vga_frame_reader dut_a (
        .clk(clk), .rst(rst), .frame_start(frame_start), .active(active),
        .pix_x(pix_x), .pix_y(pix_y), .pix_mode(pix_mode),
`ifdef VGA_READER_TEST_PATTERN_EN
        .test_en(1'b0),
`endif
        .read_addr(addr_a), .mem_data(mem_a), .out_active(act_a),
        .r(r_a), .g(g_a), .b(b_a)
    );

    vga_frame_reader #(.X0(80), .BORDER_RGB(24'hFF0000)) dut_b (
        .clk(clk), .rst(rst), .frame_start(frame_start), .active(active),
        .pix_x(pix_x), .pix_y(pix_y), .pix_mode(pix_mode),
`ifdef VGA_READER_TEST_PATTERN_EN
        .test_en(1'b0),
`endif
        .read_addr(addr_b), .mem_data(mem_b), .out_active(act_b),
        .r(r_b), .g(g_b), .b(b_b)
    );

    // Frame-buffer model: returns addr[7:0] or a forced byte, one cycle after the address.
    always @(posedge clk) begin
        mem_a <= mem_const_en ? mem_const : addr_a[7:0];
        mem_b <= mem_const_en ? mem_const : addr_b[7:0];
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
    endtask

    // Drives one pixel cycle, predicts its address/colour, then checks after the edge.
    task automatic applyStimulus(input bit rs, input bit fs, input bit ac,
                                 input int x, input int y, input bit md);
        int         slot, past;
        bit         inwin;
        logic [7:0] data;
        rst = rs; frame_start = fs; active = ac;
        pix_x = x[9:0]; pix_y = y[9:0]; pix_mode = md;
        slot = cyc % 8;
        if (rs) begin
            fv = 1'b0;
            for (int d = 0; d < 2; d++) begin
                e_addr[d] = '0;
                for (int k = 0; k < 3; k++)
                    hist_rgb[d][(cyc + 8 - k) % 8] = '0;
            end
            for (int k = 0; k < 3; k++)
                hist_act[(cyc + 8 - k) % 8] = 1'b0;
        end else begin
            hist_act[slot] = ac;
            for (int d = 0; d < 2; d++) begin
                inwin = ac && (x >= x0s[d]) && (x < x0s[d] + 640) && (y < 480);
                if (fs) begin
                    if (inwin) e_addr[d] = '0;
                end else if (fv && inwin) begin
                    e_addr[d] = 15'((y / 4) * 160 + (x - x0s[d]) / 4);
                end
                data = mem_const_en ? mem_const : e_addr[d][7:0];
                if (!ac || !(fv || fs))  hist_rgb[d][slot] = '0;
                else if (!inwin)         hist_rgb[d][slot] = borders[d];
                else if (md)             hist_rgb[d][slot] = exp332;
                else                     hist_rgb[d][slot] = {data, data, data};
            end
            if (fs) fv = 1'b1;
        end
        @(posedge clk);
        #1;
        past = (cyc + 6) % 8;
        checkOutput("addr_a", 32'(addr_a), 32'(e_addr[0]));
        checkOutput("act_a", 32'(act_a), 32'(hist_act[past]));
        checkOutput("rgb_a", 32'({r_a, g_a, b_a}), 32'(hist_rgb[0][past]));
        if (chk_b) begin
            checkOutput("addr_b", 32'(addr_b), 32'(e_addr[1]));
            checkOutput("act_b", 32'(act_b), 32'(hist_act[past]));
            checkOutput("rgb_b", 32'({r_b, g_b, b_b}), 32'(hist_rgb[1][past]));
        end
        cyc++;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 640 + i, 0, 1'b0);
    endtask

    // mode: 0 grayscale, 1 RGB332, 2 switch to RGB332 after the first four pixels.
    task automatic runLine(input int y, input int xa, input int xb, input int mode);
        bit md;
        for (int x = xa; x <= xb; x++) begin
            md = (mode == 1) || ((mode == 2) && (x >= 4));
            applyStimulus(1'b0, 1'b0, 1'b1, x, y, md);
        end
        blank(4);
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; active = 1'b0; pix_mode = 1'b0;
        pix_x = '0; pix_y = '0;
        mem_const_en = 1'b0; mem_const = 8'h00; exp332 = 24'h000000;
        e_addr[0] = '0; e_addr[1] = '0;
        for (int i = 0; i < 8; i++) begin
            hist_act[i] = 1'b0;
            hist_rgb[0][i] = '0;
            hist_rgb[1][i] = '0;
        end

        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        blank(1);

        // Active video before any frame_start must stay black with read_addr parked at 0.
        runLine(0, 0, 39, 0);

        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        for (int y = 0; y <= 4; y++)
            runLine(y, 0, 639, 0);

        mem_const_en = 1'b1;
        mem_const = 8'hE3; exp332 = 24'hFF00FF;
        runLine(5, 0, 7, 1);
        mem_const = 8'h1C; exp332 = 24'h00FF00;
        runLine(6, 0, 7, 1);
        mem_const = 8'hE3; exp332 = 24'hFF00FF;
        runLine(7, 0, 7, 2);
        mem_const_en = 1'b0;

        for (int y = 8; y <= 199; y++)
            runLine(y, 0, 7, 0);

        // The offset instance skips short lines, so its row count is not comparable on y=200.
        chk_b = 1'b0;
        for (int x = 0; x <= 299; x++)
            applyStimulus(1'b0, 1'b0, 1'b1, x, 200, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 300, 200, 1'b0);
        chk_b = 1'b1;
        for (int x = 301; x <= 639; x++)
            applyStimulus(1'b0, 1'b0, 1'b1, x, 200, 1'b0);
        blank(4);
        runLine(201, 0, 7, 0);

        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        runLine(0, 0, 639, 0);
        for (int y = 1; y <= 478; y++)
            runLine(y, 0, 7, 0);
        chk_b = 1'b0;
        runLine(479, 0, 639, 0);
        runLine(479, 0, 7, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
